mem_bist_march: RTL

- Built-in self-test controller sitting directly upstream of the 128x8 test memory.
- Drives the memory's write-enable, address and write-data lines.
- Checks both read ports: the primary port mem[addr] and the incrementer port mem[addr+1].
- Runs a March C- style sequence; reports pass/fail, the first failing location and a saturating error count.

---
 rtl/mem_bist_march.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_bist_march.sv
// March C- BIST controller for a 128x8 dual-read-port test memory.
// Drives write/address/data, checks mem[addr] and mem[addr+1], and reports
// pass/fail, first failing location and a saturating mismatch count.
module mem_bist_march #(
   parameter int                ADDR_W = 7,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BG     = 8'h55
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] mem_rdata_nxt,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_xor
);

   localparam logic [ADDR_W-1:0] A_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [2:0]        elem;
   logic [ADDR_W-1:0] addr;
   logic              phase;      // 0 = read half, 1 = write half of an r,w element
   logic              fail_seen;

   logic              running, down, rw_elem, is_wr, addr_last, op_last, run_end, mism;
   logic              launch;
   logic [DATA_W-1:0] exp_rd, wr_val, xor_p, xor_n;

   // Decode the current march operation from element/address/phase
   always_comb begin
      running   = (state == S_RUN);
      down      = (elem == 3'd3) || (elem == 3'd4);
      rw_elem   = (elem >= 3'd1) && (elem <= 3'd4);
      is_wr     = (elem == 3'd0) || (rw_elem && phase);
      exp_rd    = ((elem == 3'd2) || (elem == 3'd4)) ? ~BG : BG;
      wr_val    = ((elem == 3'd1) || (elem == 3'd3)) ? ~BG : BG;
      addr_last = down ? (addr == '0) : (addr == A_MAX);
      op_last   = !rw_elem || phase;
      run_end   = (elem == 3'd5) && addr_last;
      xor_p     = mem_rdata ^ exp_rd;
      // Only the final element also checks the incrementer port (wraps at top)
      xor_n     = (elem == 3'd5) ? (mem_rdata_nxt ^ BG) : '0;
      mism      = running && !is_wr && ((xor_p | xor_n) != '0);
      launch    = (state != S_RUN) && start;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: start only honoured outside RUN
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (run_end) state_nxt = S_DONE;
         S_DONE:  if (start) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // March sequencer: address/element/phase stepping with no dead cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem  <= '0;
         addr  <= '0;
         phase <= 1'b0;
      end else if (launch) begin
         elem  <= '0;
         addr  <= '0;
         phase <= 1'b0;
      end else if (running) begin
         phase <= rw_elem && !phase;
         if (op_last) begin
            if (run_end) begin
               elem <= '0;
               addr <= '0;
            end else if (addr_last) begin
               elem <= elem + 3'd1;
               // Elements 3 and 4 walk downward from the top address
               addr <= ((elem == 3'd2) || (elem == 3'd3)) ? A_MAX : '0;
            end else begin
               addr <= down ? addr - 1'b1 : addr + 1'b1;
            end
         end
      end
   end

   // Error accounting: saturating count, first-mismatch capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_xor  <= '0;
         fail_seen <= 1'b0;
      end else if (launch) begin
         err_count <= '0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_xor  <= '0;
         fail_seen <= 1'b0;
      end else if (mism) begin
         if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= addr;
            fail_elem <= elem;
            fail_xor  <= xor_p | xor_n;
         end
      end
   end

   // Outputs are gated by RUN so IDLE/DONE present zeros on the memory bus
   always_comb begin
      busy      = running;
      done      = (state == S_DONE);
      pass      = done && (err_count == 8'd0);
      mem_we    = running && is_wr;
      mem_addr  = running ? addr : '0;
      mem_wdata = mem_we ? wr_val : '0;
   end

endmodule
